uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO and a valid/ready byte interface. It supersedes the fixed 8N1 sender and adds:
- configurable data width, parity and stop bits;
- back-to-back framing from a buffered queue;
- a transmit-enable gate.

It sits between any byte producer (display/command logic) and the board's serial TX pin.

## Interface
- CLOCK_SPEED_MHZ, 100, clk frequency in MHz
- BAUD_RATE, 9600, line rate in bit/s
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, entries, power of two, ≥ 2

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  DATA_BITS  word to queue
- data_valid  in  1  producer offers data_in
- data_ready  out  1  FIFO can accept; equals !full
- tx_enable  in  1  permits starting new frames
- tx  out  1  serial line, registered, idle high
- busy  out  1  high while a frame is on the line (state ≠ IDLE)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- **Bit period.** CYCLES_PER_BIT = (CLOCK_SPEED_MHZ·1_000_000)/BAUD_RATE, integer-truncated. Every line bit lasts exactly CYCLES_PER_BIT clocks. The baud counter counts 0..CYCLES_PER_BIT-1 and is cleared on every state entry.
- **Push.** A push occurs on a cycle with data_valid && data_ready.
- **Pop.** A pop occurs when state is IDLE, or on the last cycle of the last stop bit, with FIFO non-empty && tx_enable.
- **Simultaneous push and pop.** fifo_count is unchanged and both words are handled correctly. A push is never accepted while full, even if a pop occurs that cycle.
- **Pop effect.** The popped word loads the shift register. Parity bit = XOR of data bits for even parity, inverted for odd parity.
- **State machine:** IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START directly.
  - IDLE: tx=1. Pop → START.
  - START: tx=0 for one bit period → DATA.
  - DATA: LSB first. Shift after each bit. After DATA_BITS bits → PARITY, or STOP if PARITY=0.
  - PARITY: one bit period → STOP.
  - STOP: tx=1 for STOP_BITS bit periods. At the end, if a pop condition holds → START with no idle gap; else → IDLE.
- **tx_enable.** Only gates frame starts. Deasserting it mid-frame lets the current frame complete, then the block stays IDLE. The FIFO keeps accepting pushes while tx_enable is low.
- **Reset (any time, including mid-frame).** Immediately: state=IDLE, tx=1, busy=0, FIFO pointers and fifo_count=0, data_ready=1. A partial frame is abandoned; the line simply returns high.
- **Out-of-range parameters.** Out-of-range DATA_BITS, PARITY or STOP_BITS values are a synthesis-time error via generate-time check.

## Timing
- **Reset values:** tx=1, busy=0, data_ready=1, fifo_count=0.
- **Push visibility.** A push at cycle N is visible in fifo_count at N+1.
- **Empty-FIFO start latency.** With the FIFO empty, IDLE and tx_enable=1, a push at cycle N gives:
  - pop at N+1;
  - tx falls at N+2;
  - busy rises at N+2.
- **Frame length.** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CYCLES_PER_BIT clocks.
- **Back-to-back frames.** Consecutive queued frames have zero idle cycles between the final stop bit and the next start bit.
- **data_ready.** Combinational from the full flag; it falls the cycle after the push that fills the FIFO.

## Test plan
Unless stated: CLOCK_SPEED_MHZ=1, BAUD_RATE=100000 → CYCLES_PER_BIT=10.

- **8N1 single frame.** Push 0x46 → start bit low for 10 cycles, then bits 0,1,1,0,0,0,1,0 at 10 cycles each, then 10 cycles high. Total 100 cycles from the tx fall; busy drops at cycle 100.
- **Parity.** PARITY=2, push 0x07 → parity bit 1. PARITY=1, push 0x07 → parity bit 0. Frame is 110 cycles.
- **7-bit data, 2 stop bits.** DATA_BITS=7, STOP_BITS=2, push 0x55 → 100-cycle frame with 20 high cycles at the end.
- **Full FIFO and back-to-back.** FIFO_DEPTH=4, tx_enable=0, push 0xA1..0xA4 → fifo_count=4, data_ready=0, and a fifth valid word (0xA5) is held off. Raise tx_enable →
  - five frames in order 0xA1..0xA5;
  - no idle cycles between frames;
  - data_ready returns high the cycle after the first pop.
- **tx_enable mid-frame.** Drop tx_enable during the data bits of frame 1 with 2 words queued → frame 1 completes, tx stays high, fifo_count=1.
- **Reset mid-frame.** Assert rst_n=0 in the 3rd data bit with 3 words queued → immediately tx=1, busy=0, fifo_count=0. After release, no frame starts until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO over a valid/ready byte interface.
// Configurable data width, parity and stop bits. Queued frames go out back to back.
module uart_tx_fifo #(
    parameter int CLOCK_SPEED_MHZ = 100,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          tx_enable,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = (CLOCK_SPEED_MHZ * 1000000) / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CPB < 1) begin : g_bad_baud
        $error("uart_tx_fifo: BAUD_RATE too high for clock");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full, empty, push, pop;
    logic                 bit_end, stop_end, par_bit;
    logic [DATA_BITS-1:0] head;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign data_ready = !full;
    assign fifo_count = count;
    assign busy       = (state != S_IDLE);

    assign bit_end  = (baud_cnt == CW'(CPB - 1));
    assign stop_end = (state == S_STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
    // A push is gated only by full, so it can never ride on a same-cycle pop.
    assign push     = data_valid && !full;
    assign pop      = tx_enable && !empty && ((state == S_IDLE) || stop_end);

    assign head    = mem[rd_ptr];
    assign par_bit = (^head) ^ (PARITY == 1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // tx is registered alongside the state, so each transition also sets the first level of the new bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        state <= S_START;
                        tx    <= 1'b0;
                        shreg <= head;
                        par_q <= par_bit;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PAR;
                                tx    <= par_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state <= S_START;
                                tx    <= 1'b0;
                                shreg <= head;
                                par_q <= par_bit;
                            end else begin
                                state <= S_IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations side by side (8N1, 8E1, 8O1, 7N2), depth 4,
// each compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int N   = 4;
    localparam int CPB = 10;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0][8:0] din;
    logic [N-1:0]      dv, en;
    wire  [N-1:0]      tx, busy, dr;
    wire  [N-1:0][2:0] cnt;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DB = (g == 3) ? 7 : 8;
        localparam int P  = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB = (g == 3) ? 2 : 1;
        uart_tx_fifo #(
            .CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(DB),
            .PARITY(P), .STOP_BITS(SB), .FIFO_DEPTH(DEP)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .data_in(din[g][DB-1:0]), .data_valid(dv[g]),
            .data_ready(dr[g]), .tx_enable(en[g]), .tx(tx[g]), .busy(busy[g]),
            .fifo_count(cnt[g])
        );
    end

    function automatic int db_of(int k);  return (k == 3) ? 7 : 8; endfunction
    function automatic int par_of(int k); return (k == 1) ? 2 : (k == 2) ? 1 : 0; endfunction
    function automatic int sb_of(int k);  return (k == 3) ? 2 : 1; endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of words plus the current frame as a flat bit list.
    logic [8:0]  mbuf [N][16];
    int          hd [N], tl [N], flen [N], fpos [N];
    bit          act [N];
    logic [15:0] fb [N];

    always @(posedge clk or negedge rst_n) begin
        int   c;
        bit   last, pp, ps;
        logic [8:0] w;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                hd[k] = 0; tl[k] = 0; act[k] = 0; fpos[k] = 0; flen[k] = 1; fb[k] = '1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c    = tl[k] - hd[k];
                last = act[k] && (fpos[k] == flen[k] * CPB - 1);
                pp   = en[k] && (c > 0) && (!act[k] || last);
                ps   = dv[k] && (c < DEP);
                if (act[k]) begin
                    fpos[k]++;
                    if (fpos[k] == flen[k] * CPB) begin
                        act[k] = 0; fpos[k] = 0;
                    end
                end
                if (pp) begin
                    w = mbuf[k][hd[k] % 16];
                    hd[k]++;
                    fb[k] = '1;
                    fb[k][0] = 1'b0;
                    for (int i = 0; i < db_of(k); i++) fb[k][1+i] = w[i];
                    if (par_of(k) != 0) fb[k][1+db_of(k)] = (^w) ^ (par_of(k) == 1);
                    flen[k] = 1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k);
                    act[k]  = 1; fpos[k] = 0;
                end
                if (ps) begin
                    w = din[k];
                    for (int i = 0; i < 9; i++) if (i >= db_of(k)) w[i] = 1'b0;
                    mbuf[k][tl[k] % 16] = w;
                    tl[k]++;
                end
            end
        end
    end

    int blen [N];
    initial for (int k = 0; k < N; k++) blen[k] = 0;

    always @(posedge clk) begin
        logic etx;
        #1;
        for (int k = 0; k < N; k++) begin
            etx = act[k] ? fb[k][fpos[k] / CPB] : 1'b1;
            chk($sformatf("cyc_tx%0d", k),   32'(tx[k]),   32'(etx));
            chk($sformatf("cyc_busy%0d", k), 32'(busy[k]), 32'(act[k]));
            chk($sformatf("cyc_cnt%0d", k),  32'(cnt[k]),  32'(tl[k] - hd[k]));
            chk($sformatf("cyc_rdy%0d", k),  32'(dr[k]),   32'((tl[k] - hd[k]) < DEP));
            if (busy[k]) blen[k]++;
        end
    end

    initial begin
        int b0 [N];
        int t;
        dv = '0; en = '0; din = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_tx", 32'(tx[k]), 1);
            chk("rst_busy", 32'(busy[k]), 0);
            chk("rst_rdy", 32'(dr[k]), 1);
            chk("rst_cnt", 32'(cnt[k]), 0);
        end
        rst_n = 1'b1;

        // Single frames: 0x46 8N1, 0x07 even, 0x07 odd, 0x55 7N2
        @(negedge clk);
        for (int k = 0; k < N; k++) b0[k] = blen[k];
        en = '1;
        din[0] = 9'h46; din[1] = 9'h07; din[2] = 9'h07; din[3] = 9'h55;
        dv = '1;
        @(negedge clk);
        dv = '0;
        repeat (130) @(negedge clk);
        chk("len_8n1", 32'(blen[0] - b0[0]), 100);
        chk("len_8e1", 32'(blen[1] - b0[1]), 110);
        chk("len_8o1", 32'(blen[2] - b0[2]), 110);
        chk("len_7n2", 32'(blen[3] - b0[3]), 100);

        // Fill with transmit disabled, hold a fifth word, then release
        en = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) din[k] = 9'(8'hA1 + i);
            dv = '1;
            @(negedge clk);
        end
        for (int k = 0; k < N; k++) din[k] = 9'h0A5;
        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("full_cnt", 32'(cnt[k]), 4);
            chk("full_rdy", 32'(dr[k]), 0);
        end
        en = '1;
        t = 0;
        while (!dr[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("rdy_timeout", 0, 1);
        @(negedge clk);
        dv = '0;
        repeat (5 * 110 + 40) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("b2b_cnt", 32'(cnt[k]), 0);
            chk("b2b_busy", 32'(busy[k]), 0);
        end

        // tx_enable dropped during data bits of frame 1
        for (int k = 0; k < N; k++) din[k] = 9'h03C;
        dv = '1;
        @(negedge clk);
        for (int k = 0; k < N; k++) din[k] = 9'h0C3;
        @(negedge clk);
        dv = '0;
        repeat (40) @(negedge clk);
        en = '0;
        repeat (150) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("en_busy", 32'(busy[k]), 0);
            chk("en_tx", 32'(tx[k]), 1);
            chk("en_cnt", 32'(cnt[k]), 1);
        end
        en = '1;
        repeat (130) @(negedge clk);

        // Reset in the third data bit with three words queued
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) din[k] = 9'(8'h11 * (i + 1));
            dv = '1;
            @(negedge clk);
        end
        dv = '0;
        repeat (30) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("pre_rst_busy", 32'(busy[k]), 1);
            chk("pre_rst_cnt", 32'(cnt[k]), 3);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("mid_rst_tx", 32'(tx[k]), 1);
            chk("mid_rst_busy", 32'(busy[k]), 0);
            chk("mid_rst_cnt", 32'(cnt[k]), 0);
            chk("mid_rst_rdy", 32'(dr[k]), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("post_rst_busy", 32'(busy[k]), 0);
            chk("post_rst_tx", 32'(tx[k]), 1);
        end

        // Random traffic, then drain
        repeat (3000) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                dv[k]  = ($urandom_range(0, 3) == 0);
                din[k] = 9'($urandom);
                en[k]  = ($urandom_range(0, 19) != 0);
            end
        end
        @(negedge clk);
        dv = '0; en = '1;
        repeat (700) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("drain_cnt", 32'(cnt[k]), 0);
            chk("drain_busy", 32'(busy[k]), 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
